// File: rtl/led_mmio_periph_if.sv
`default_nettype none
// ============================================================================
// Module   : led_mmio_periph_if
// Brief    : picorv32 native memory bus bundle for the LED peripheral.
// Revision : 1.0 - initial release
// ============================================================================
interface led_mmio_periph_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/led_mmio_periph.sv
`default_nettype none
// ============================================================================
// Module   : led_mmio_periph
// Brief    : Memory-mapped LED register block with set/clear/toggle ports and
//            a hardware blink engine, one-wait-state picorv32 bus slave.
// Revision : 1.0 - initial release
// ============================================================================
module led_mmio_periph #(
    parameter logic [31:0]          BASE_ADDR  = 32'h1000_0000,
    parameter int                   NUM_LEDS   = 10,
    parameter int                   PERIOD_W   = 24,
    parameter logic [NUM_LEDS-1:0]  RESET_LEDS = '0
) (
    input  logic                clk,
    input  logic                resetn,
    led_mmio_periph_if.slave    bus,
    output logic [NUM_LEDS-1:0] ledr
);

    localparam logic [2:0] c_OFF_LED    = 3'd0;
    localparam logic [2:0] c_OFF_SET    = 3'd1;
    localparam logic [2:0] c_OFF_CLR    = 3'd2;
    localparam logic [2:0] c_OFF_TGL    = 3'd3;
    localparam logic [2:0] c_OFF_MASK   = 3'd4;
    localparam logic [2:0] c_OFF_PERIOD = 3'd5;
    localparam logic [2:0] c_OFF_STATUS = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_LEDS-1:0]   r_led;
    logic [NUM_LEDS-1:0]   r_mask;
    logic [PERIOD_W-1:0]   r_period;
    logic [PERIOD_W-1:0]   r_cnt;
    logic                  r_phase;

    logic                  w_sel;
    logic [2:0]            w_off;
    logic                  w_wr;
    logic [31:0]           w_wmask;
    logic [31:0]           w_op;
    logic [NUM_LEDS-1:0]   w_led_nxt;
    logic [NUM_LEDS-1:0]   w_mask_nxt;
    logic [PERIOD_W-1:0]   w_period_nxt;
    logic                  w_period_wr;
    logic [PERIOD_W-1:0]   w_period_m1;
    logic [31:0]           w_rdval;
    logic                  w_unused;

    assign w_sel       = bus.mem_valid && (bus.mem_addr[31:5] == BASE_ADDR[31:5]);
    assign w_off       = bus.mem_addr[4:2];
    assign w_wr        = (r_state == S_IDLE) && w_sel && (|bus.mem_wstrb);
    assign w_wmask     = {{8{bus.mem_wstrb[3]}}, {8{bus.mem_wstrb[2]}},
                          {8{bus.mem_wstrb[1]}}, {8{bus.mem_wstrb[0]}}};
    assign w_op        = bus.mem_wdata & w_wmask;
    assign w_period_m1 = r_period - PERIOD_W'(1);
    assign w_unused    = ^{bus.mem_addr[1:0], bus.mem_wdata};

    // Register write decode; only strobed bytes of the operand participate.
    always_comb begin
        w_led_nxt    = r_led;
        w_mask_nxt   = r_mask;
        w_period_nxt = r_period;
        w_period_wr  = 1'b0;
        if (w_wr) begin
            case (w_off)
                c_OFF_LED:    w_led_nxt  = (r_led & ~w_wmask[NUM_LEDS-1:0]) | w_op[NUM_LEDS-1:0];
                c_OFF_SET:    w_led_nxt  = r_led | w_op[NUM_LEDS-1:0];
                c_OFF_CLR:    w_led_nxt  = r_led & ~w_op[NUM_LEDS-1:0];
                c_OFF_TGL:    w_led_nxt  = r_led ^ w_op[NUM_LEDS-1:0];
                c_OFF_MASK:   w_mask_nxt = (r_mask & ~w_wmask[NUM_LEDS-1:0]) | w_op[NUM_LEDS-1:0];
                c_OFF_PERIOD: begin
                    w_period_nxt = (r_period & ~w_wmask[PERIOD_W-1:0]) | w_op[PERIOD_W-1:0];
                    w_period_wr  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rdval = '0;
        case (w_off)
            c_OFF_LED, c_OFF_SET,
            c_OFF_CLR, c_OFF_TGL: w_rdval = 32'(r_led);
            c_OFF_MASK:           w_rdval = 32'(r_mask);
            c_OFF_PERIOD:         w_rdval = 32'(r_period);
            c_OFF_STATUS:         w_rdval = {30'b0, |r_period, r_phase};
            default:              w_rdval = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        case (r_state)
            S_IDLE: if (w_sel) w_state_nxt = S_ACK;
            S_ACK: begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = w_rdval;
                w_state_nxt   = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A period write restarts the blink cycle from phase 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_led    <= RESET_LEDS;
            r_mask   <= '0;
            r_period <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else begin
            r_led    <= w_led_nxt;
            r_mask   <= w_mask_nxt;
            r_period <= w_period_nxt;
            if (w_period_wr || (r_period == '0)) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (r_cnt == w_period_m1) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt + PERIOD_W'(1);
            end
        end
    end

    assign ledr = r_led ^ (r_mask & {NUM_LEDS{r_phase}});

endmodule
`default_nettype wire

// File: tb/tb_led_mmio_periph.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_mmio_periph
// Brief    : Directed plus randomized bench for led_mmio_periph with a
//            time-based behavioural model of the register file and blinker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_mmio_periph;

    localparam logic [31:0] c_BASE  = 32'h1000_0000;
    localparam int          c_NL    = 10;
    localparam int          c_PW    = 24;
    localparam logic [31:0] c_LMASK = 32'h0000_03FF;
    localparam logic [31:0] c_PMASK = 32'h00FF_FFFF;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [c_NL-1:0] ledr;
    int              cyc = 0;
    int              vectors = 0;
    int              miscompares = 0;

    led_mmio_periph_if bus ();

    led_mmio_periph #(
        .BASE_ADDR  (c_BASE),
        .NUM_LEDS   (c_NL),
        .PERIOD_W   (c_PW),
        .RESET_LEDS ('0)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave),
        .ledr   (ledr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: registers plus the cycle at which the blink cycle restarted.
    logic [31:0] m_led, m_mask, m_period;
    int          t0;

    function automatic logic m_phase();
        if (m_period == 0) return 1'b0;
        return ((32'(cyc - t0) / m_period) % 2) == 1;
    endfunction

    function automatic logic [31:0] m_ledr();
        return m_led ^ (m_phase() ? m_mask : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] off);
        case (off)
            3'd0, 3'd1, 3'd2, 3'd3: return m_led;
            3'd4: return m_mask;
            3'd5: return m_period;
            3'd6: return {30'b0, m_period != 0, m_phase()};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_led = 0; m_mask = 0; m_period = 0; t0 = cyc;
    endtask

    task automatic m_write(input logic [2:0] off, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] bm, op;
        bm = 0;
        for (int k = 0; k < 4; k++) if (ws[k]) bm = bm | (32'hFF << (8 * k));
        op = wd & bm;
        case (off)
            3'd0: m_led    = ((m_led & ~bm) | op) & c_LMASK;
            3'd1: m_led    = (m_led | op) & c_LMASK;
            3'd2: m_led    = m_led & ~op;
            3'd3: m_led    = (m_led ^ op) & c_LMASK;
            3'd4: m_mask   = ((m_mask & ~bm) | op) & c_LMASK;
            3'd5: begin
                m_period = ((m_period & ~bm) | op) & c_PMASK;
                t0 = cyc;
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the bus idle; returns at a negedge, bus idle.
    task automatic access(input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, output logic [31:0] rd);
        logic in_win;
        in_win = (addr[31:5] == c_BASE[31:5]);
        bus.mem_valid = 1'b1; bus.mem_addr = addr; bus.mem_wdata = wd; bus.mem_wstrb = ws;
        #1;
        chk("ready_before_edge", 32'(bus.mem_ready), 32'd0);
        @(negedge clk);
        if (in_win) begin
            if (ws != 4'b0) m_write(addr[4:2], wd, ws);
            chk("ready_ack", 32'(bus.mem_ready), 32'd1);
            chk("rdata_ack", bus.mem_rdata, m_read(addr[4:2]));
            chk("ledr_ack", 32'(ledr), m_ledr());
        end else begin
            chk("ready_outside", 32'(bus.mem_ready), 32'd0);
            chk("rdata_outside", bus.mem_rdata, 32'd0);
        end
        rd = bus.mem_rdata;
        bus.mem_valid = 1'b0; bus.mem_wstrb = 4'b0;
        @(negedge clk);
        chk("ready_single_cycle", 32'(bus.mem_ready), 32'd0);
        chk("ledr_after", 32'(ledr), m_ledr());
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("ready_idle", 32'(bus.mem_ready), 32'd0);
            chk("rdata_idle", bus.mem_rdata, 32'd0);
            chk("ledr_idle", 32'(ledr), m_ledr());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a, wd;
        logic [3:0]  ws;
        logic [2:0]  off;

        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
        m_reset();

        // Step 1: long reset
        resetn = 1'b0;
        repeat (100) @(negedge clk);
        chk("reset_ledr", 32'(ledr), 32'd0);
        chk("reset_ready", 32'(bus.mem_ready), 32'd0);
        resetn = 1'b1;
        m_reset();
        access(c_BASE + 32'h18, 0, 4'b0, rd);
        chk("reset_status", rd, 32'd0);

        // Step 2: basic write and readback
        access(c_BASE, 32'h1, 4'hF, rd);
        chk("s2_ledr", 32'(ledr), 32'h001);
        access(c_BASE, 0, 4'b0, rd);
        chk("s2_readback", rd, 32'h1);

        // Step 3: set / clear / toggle
        access(c_BASE + 32'h04, 32'h300, 4'hF, rd);
        access(c_BASE + 32'h08, 32'h001, 4'hF, rd);
        access(c_BASE + 32'h0C, 32'h0F0, 4'hF, rd);
        chk("s3_ledr", 32'(ledr), 32'h3F0);
        access(c_BASE, 0, 4'b0, rd);
        chk("s3_read", rd, 32'h3F0);
        access(c_BASE + 32'h08, 0, 4'b0, rd);
        chk("s3_wo_read", rd, 32'h3F0);

        // Back-to-back: a held request is acked every second cycle
        bus.mem_valid = 1'b1; bus.mem_addr = c_BASE; bus.mem_wstrb = 4'b0;
        @(negedge clk); chk("b2b_ack1", 32'(bus.mem_ready), 32'd1);
        @(negedge clk); chk("b2b_gap", 32'(bus.mem_ready), 32'd0);
        @(negedge clk); chk("b2b_ack2", 32'(bus.mem_ready), 32'd1);
        bus.mem_valid = 1'b0;
        idle(1);

        // Step 4: blink engine
        access(c_BASE + 32'h10, 32'h003, 4'hF, rd);
        access(c_BASE + 32'h14, 32'd4, 4'hF, rd);
        idle(3);
        chk("s4_blink_on", 32'(ledr), 32'h3F3);
        access(c_BASE + 32'h18, 0, 4'b0, rd);
        idle(13);
        access(c_BASE + 32'h14, 32'd0, 4'hF, rd);
        chk("s4_period0_ledr", 32'(ledr), 32'h3F0);
        access(c_BASE + 32'h18, 0, 4'b0, rd);
        chk("s4_period0_status", rd, 32'd0);

        // Step 5: byte strobes, then async reset mid-blink
        access(c_BASE, 32'h0, 4'hF, rd);
        access(c_BASE, 32'hFFFF_FFFF, 4'b0010, rd);
        chk("s5_strobe", 32'(ledr), 32'h300);
        access(c_BASE + 32'h14, 32'd3, 4'hF, rd);
        idle(5);
        #2 resetn = 1'b0;
        #1;
        m_reset();
        chk("s5_async_ledr", 32'(ledr), 32'd0);
        chk("s5_async_ready", 32'(bus.mem_ready), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        access(c_BASE + 32'h14, 0, 4'b0, rd);
        access(c_BASE + 32'h10, 0, 4'b0, rd);

        // Reset during an access: no ack, no write
        bus.mem_valid = 1'b1; bus.mem_addr = c_BASE; bus.mem_wdata = 32'h155; bus.mem_wstrb = 4'hF;
        #2 resetn = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.mem_ready), 32'd0);
        bus.mem_valid = 1'b0; bus.mem_wstrb = 4'b0;
        resetn = 1'b1;
        m_reset();
        idle(2);

        // Step 6: reserved offset and out-of-window access
        access(c_BASE + 32'h1C, 32'hDEAD_BEEF, 4'hF, rd);
        chk("s6_reserved", rd, 32'd0);
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h2000_0000; bus.mem_wdata = 32'h3FF; bus.mem_wstrb = 4'hF;
        repeat (20) begin
            @(negedge clk);
            chk("s6_outside_ready", 32'(bus.mem_ready), 32'd0);
        end
        bus.mem_valid = 1'b0; bus.mem_wstrb = 4'b0;
        idle(1);

        // Randomized traffic against the model
        for (int i = 0; i < 200; i++) begin
            off = 3'($urandom_range(0, 7));
            ws  = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
            wd  = $urandom;
            if (off == 3'd5) wd = $urandom_range(0, 9);
            a = c_BASE + {27'b0, off, 2'b00};
            if ($urandom_range(0, 9) == 0) a = a + 32'h20;
            access(a, wd, ws, rd);
            idle($urandom_range(0, 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
